demux_1_4_stream: RTL and testbench

//  1-to-4 packet demultiplexer: the receive-side counterpart of the team's 4:1 mux tree.

---
 rtl/demux_1_4_stream_if.sv | 16 +
 rtl/demux_1_4_stream.sv | 74 +++++++
 tb/tb_demux_1_4_stream.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_stream_if.sv
// demux_1_4_stream_if: valid/ready input stream plus four-channel output bus
interface demux_1_4_stream_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic [1:0]        s_sel;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [3:0]        m_valid;
  logic [3:0]        m_ready;
  modport slave (input s_data, s_valid, s_last, s_sel, m_ready,
                 output s_ready, m_data, m_last, m_valid);
  modport master (output s_data, s_valid, s_last, s_sel, m_ready,
                  input s_ready, m_data, m_last, m_valid);
endinterface

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1-to-4 packet demux, route locked per packet, one output register stage
// Define DEMUX_PKT_CNT_EN to build the per-channel 16-bit completed-packet counters.
module demux_1_4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1_4_stream_if.slave   io,
  output logic [63:0]         pkt_cnt
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [1:0]        route_q, route_d;
  logic [3:0]        m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [1:0]        o_ch, ch;
  logic              o_full, s_ready, accept;
  always_comb begin
    o_full    = |m_valid_q;
    o_ch      = {m_valid_q[3] | m_valid_q[2], m_valid_q[3] | m_valid_q[1]};
    s_ready   = rst_n && (!o_full || io.m_ready[o_ch]);
    accept    = io.s_valid && s_ready;
    ch        = state_q == LOCKED ? route_q : io.s_sel;
    state_d   = state_q;
    route_d   = route_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (accept) begin
      m_valid_d = 4'b0001 << ch;
      m_data_d  = io.s_data;
      m_last_d  = io.s_last;
      route_d   = ch;
      state_d   = io.s_last ? IDLE : LOCKED;
    end else if (o_full && io.m_ready[o_ch]) begin
      m_valid_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      route_q   <= '0;
      m_valid_q <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      route_q   <= route_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end
  assign io.s_ready = s_ready;
  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_last  = m_last_q;
`ifdef DEMUX_PKT_CNT_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  always_comb begin
    for (int i = 0; i < 4; i++)
      cnt_d[i] = cnt_q[i] + 16'(m_valid_q[i] && io.m_ready[i] && m_last_q);
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      cnt_q[i] <= rst_n ? cnt_d[i] : 16'h0;
  end
  assign pkt_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign pkt_cnt = 64'h0;
`endif
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: scenario tasks drive packets; a scoreboard of expected beats
// is filled on accept and drained by a monitor as beats complete on the outputs.
module tb_demux_1_4_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pkt_cnt;
  demux_1_4_stream_if #(.DATA_W(8)) bus();
  demux_1_4_stream #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .io(bus), .pkt_cnt(pkt_cnt));
  always #5 clk = ~clk;

  typedef struct {logic [1:0] ch; logic [7:0] d; logic l;} beat_t;
  beat_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        locked = 1'b0;
  logic [1:0]  route = 2'd0;
  logic [15:0] exp_cnt [4];
  logic        prev_stall = 1'b0;
  logic [10:0] prev_in = '0;
  beat_t       mon_e;
  logic [1:0]  mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_pkt();
`ifdef DEMUX_PKT_CNT_EN
    return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
    return 64'h0;
`endif
  endfunction

  // Monitor: every beat completing on a channel must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(bus.m_valid)) begin
        failures++;
        $display("FAIL onehot: m_valid=%b, required one-hot or zero", bus.m_valid);
      end
      if (prev_stall) begin
        checks++;
        if (!bus.s_valid || {bus.s_data, bus.s_last, bus.s_sel} !== prev_in) begin
          failures++;
          $display("FAIL protocol: input changed while stalled, now v=%b %h, held %h",
                   bus.s_valid, {bus.s_data, bus.s_last, bus.s_sel}, prev_in);
        end
      end
      if ((bus.m_valid & bus.m_ready) != 4'b0) begin
        mon_c = 2'd0;
        for (int i = 0; i < 4; i++) if (bus.m_valid[i]) mon_c = 2'(i);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_empty: unexpected beat ch=%0d data=%h, required none", mon_c, bus.m_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_c !== mon_e.ch || bus.m_data !== mon_e.d || bus.m_last !== mon_e.l) begin
            failures++;
            $display("FAIL beat: got ch=%0d data=%h last=%b, required ch=%0d data=%h last=%b",
                     mon_c, bus.m_data, bus.m_last, mon_e.ch, mon_e.d, mon_e.l);
          end
          if (mon_e.l) exp_cnt[mon_e.ch] = exp_cnt[mon_e.ch] + 16'd1;
        end
      end
    end
    prev_stall = rst_n && bus.s_valid && !bus.s_ready;
    prev_in = {bus.s_data, bus.s_last, bus.s_sel};
  end

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] sel, output int acc_cyc);
    logic  acc = 1'b0;
    beat_t b;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_sel   = sel;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.s_ready;
      if (acc) begin
        b.ch = locked ? route : sel;
        b.d  = d;
        b.l  = l;
        sb.push_back(b);
        route  = b.ch;
        locked = !l;
      end
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    bus.s_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: data=%h not accepted, required accept within 50 cycles", d);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    sb.delete();
    locked = 1'b0;
    route  = 2'd0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'h0;
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.s_last  = 1'b0;
    bus.s_sel   = 2'd1;
    bus.m_ready = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks += 4;
    if (bus.m_valid !== 4'b0000) begin failures++; $display("FAIL reset_m_valid: got %b, required 0000", bus.m_valid); end
    if (bus.m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h, required 00", bus.m_data); end
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b, required 0", bus.s_ready); end
    if (pkt_cnt !== 64'h0) begin failures++; $display("FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt); end
    do_reset(0);
  endtask

  task automatic test_single();
    int c;
    bus.m_ready = 4'hF;
    send(8'hA5, 1'b1, 2'd2, c);
    checks += 3;
    if (bus.m_valid !== 4'b0100) begin failures++; $display("FAIL single_m_valid: got %b, required 0100", bus.m_valid); end
    if (bus.m_data !== 8'hA5) begin failures++; $display("FAIL single_m_data: got %h, required a5", bus.m_data); end
    if (bus.m_last !== 1'b1) begin failures++; $display("FAIL single_m_last: got %b, required 1", bus.m_last); end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL single_drain: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_route_lock();
    int c0, c;
    bus.m_ready = 4'hF;
    send(8'h10, 1'b0, 2'd1, c0);
    checks++;
    if (bus.m_last !== 1'b0) begin failures++; $display("FAIL lock_first_last: got %b, required 0", bus.m_last); end
    for (int i = 1; i < 4; i++) begin
      send(8'(8'h10 + i), i == 3, 2'd3, c);
      checks++;
      if (c != c0 + i) begin failures++; $display("FAIL lock_cycle: beat %0d at cycle %0d, required %0d", i, c, c0 + i); end
    end
    checks += 3;
    if (bus.m_valid !== 4'b0010) begin failures++; $display("FAIL lock_m_valid: got %b, required 0010", bus.m_valid); end
    if (bus.m_data !== 8'h13) begin failures++; $display("FAIL lock_m_data: got %h, required 13", bus.m_data); end
    if (bus.m_last !== 1'b1) begin failures++; $display("FAIL lock_m_last: got %b, required 1", bus.m_last); end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL lock_drain: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int c;
    bus.m_ready = 4'b1110;
    send(8'h20, 1'b1, 2'd0, c);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h21;
    bus.s_last  = 1'b1;
    bus.s_sel   = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready: cycle %0d got %b, required 0", i, bus.s_ready); end
      if (bus.m_data !== 8'h20) begin failures++; $display("FAIL bp_m_data: cycle %0d got %h, required 20", i, bus.m_data); end
      if (bus.m_valid !== 4'b0001) begin failures++; $display("FAIL bp_m_valid: cycle %0d got %b, required 0001", i, bus.m_valid); end
    end
    bus.m_ready = 4'hF;
    send(8'h21, 1'b1, 2'd0, c);
    wait_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL bp_drain: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int c0, c;
    bus.m_ready = 4'hF;
    send(8'hC3, 1'b1, 2'd3, c0);
    checks++;
    if (bus.m_valid !== 4'b1000) begin failures++; $display("FAIL b2b_first: got %b, required 1000", bus.m_valid); end
    send(8'h0C, 1'b1, 2'd0, c);
    checks += 3;
    if (bus.m_valid !== 4'b0001) begin failures++; $display("FAIL b2b_second: got %b, required 0001", bus.m_valid); end
    if (bus.m_data !== 8'h0C) begin failures++; $display("FAIL b2b_data: got %h, required 0c", bus.m_data); end
    if (c != c0 + 1) begin failures++; $display("FAIL b2b_cycle: second at %0d, required %0d", c, c0 + 1); end
    wait_drain();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain: %0d beats left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [15:0] e1, e2;
`ifdef DEMUX_PKT_CNT_EN
    e1 = 16'h0; e2 = 16'h1;
`else
    e1 = 16'h0; e2 = 16'h0;
`endif
    bus.m_ready = 4'hF;
    send(8'h40, 1'b0, 2'd1, c);
    send(8'h41, 1'b0, 2'd1, c);
    do_reset(2);
    send(8'h50, 1'b0, 2'd2, c);
    checks++;
    if (bus.m_valid !== 4'b0100) begin failures++; $display("FAIL mid_route: got %b, required 0100", bus.m_valid); end
    send(8'h51, 1'b1, 2'd1, c);
    wait_drain();
    checks += 4;
    if (sb.size() != 0) begin failures++; $display("FAIL mid_drain: %0d beats left, required 0", sb.size()); end
    if (pkt_cnt[31:16] !== e1) begin failures++; $display("FAIL mid_cnt1: got %h, required %h", pkt_cnt[31:16], e1); end
    if (pkt_cnt[47:32] !== e2) begin failures++; $display("FAIL mid_cnt2: got %h, required %h", pkt_cnt[47:32], e2); end
    if (pkt_cnt !== exp_pkt()) begin failures++; $display("FAIL mid_cnt: got %h, required %h", pkt_cnt, exp_pkt()); end
  endtask

  task automatic test_wrap();
    int c;
    bus.m_ready = 4'hF;
`ifdef DEMUX_PKT_CNT_EN
    for (int i = 0; i < 65535; i++) send(8'(i), 1'b1, 2'd0, c);
    wait_drain();
    checks++;
    if (pkt_cnt[15:0] !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre: got %h, required ffff", pkt_cnt[15:0]); end
    send(8'hEE, 1'b1, 2'd0, c);
    wait_drain();
    checks++;
    if (pkt_cnt[15:0] !== 16'h0) begin failures++; $display("FAIL wrap_post: got %h, required 0000", pkt_cnt[15:0]); end
`else
    for (int i = 0; i < 3; i++) send(8'(i), 1'b1, 2'd0, c);
    wait_drain();
`endif
    checks += 2;
    if (sb.size() != 0) begin failures++; $display("FAIL wrap_drain: %0d beats left, required 0", sb.size()); end
    if (pkt_cnt !== exp_pkt()) begin failures++; $display("FAIL wrap_cnt: got %h, required %h", pkt_cnt, exp_pkt()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'h0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h0;
    bus.s_last  = 1'b0;
    bus.s_sel   = 2'd0;
    bus.m_ready = 4'hF;
    test_reset();
    test_single();
    test_route_lock();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
